// File: rtl/ff_excitation_driver.sv
// Excitation engine and self-checker for a bank of external SR/JK/D/T flip-flops.
// Optional FF_ERR_COUNT_EN adds a saturating mismatch counter (err_count) with synchronous clear (err_clr).
module ff_excitation_driver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] tgt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] exc_a,
    output logic [WIDTH-1:0] exc_b,
    output logic             done,
    output logic             mismatch,
    output logic [WIDTH-1:0] mismatch_bits
`ifdef FF_ERR_COUNT_EN
    ,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
`endif
);

    typedef enum logic [1:0] {
        FF_SR = 2'b00,
        FF_JK = 2'b01,
        FF_D  = 2'b10,
        FF_T  = 2'b11
    } ff_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_APPLY = 2'b01,
        S_CHECK = 2'b10
    } state_e;

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
        $error("WIDTH and CNT_W must both be at least 1");
    end

    state_e           r_state;
    state_e           w_state_next;
    ff_type_e         r_mode;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_exc_a;
    logic [WIDTH-1:0] r_exc_b;
    logic             r_done;
    logic             r_mismatch;
    logic [WIDTH-1:0] r_mm_bits;

    logic             w_accept;
    logic [WIDTH-1:0] w_exc_a_next;
    logic [WIDTH-1:0] w_exc_b_next;
    logic [WIDTH-1:0] w_mm_bits;
    logic             w_check_end;

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: w_state_next = S_CHECK;
            S_CHECK: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Excitation from the live request; don't-care entries resolve to 0.
    always_comb begin
        w_exc_a_next = '0;
        w_exc_b_next = '0;
        unique case (ff_type_e'(mode))
            FF_SR, FF_JK: begin
                w_exc_a_next = ~q_fb & tgt;
                w_exc_b_next = q_fb & ~tgt;
            end
            FF_D:    w_exc_a_next = tgt;
            FF_T:    w_exc_a_next = q_fb ^ tgt;
            default: w_exc_a_next = '0;
        endcase
    end

    assign w_mm_bits   = q_fb ^ r_tgt;
    assign w_check_end = (r_state == S_CHECK);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= FF_SR;
            r_tgt      <= '0;
            r_exc_a    <= '0;
            r_exc_b    <= '0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_mm_bits  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_check_end;
            if (w_accept) begin
                r_mode  <= ff_type_e'(mode);
                r_tgt   <= tgt;
                r_exc_a <= w_exc_a_next;
                r_exc_b <= w_exc_b_next;
            end
            if (w_check_end) begin
                r_mm_bits  <= w_mm_bits;
                r_mismatch <= |w_mm_bits;
            end
        end
    end

    // Outside APPLY the bank must hold: D mode feeds Q back, the others drive all-zero.
    always_comb begin
        exc_a = '0;
        exc_b = '0;
        if (r_state == S_APPLY) begin
            exc_a = r_exc_a;
            exc_b = r_exc_b;
        end else if (r_mode == FF_D) begin
            exc_a = q_fb;
        end
    end

    assign done          = r_done;
    assign mismatch      = r_mismatch;
    assign mismatch_bits = r_mm_bits;

`ifdef FF_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_check_end && (|w_mm_bits) && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Directed self-checking bench for ff_excitation_driver with a behavioural flip-flop bank on q_fb.
// Define FF_ERR_COUNT_EN to also exercise the saturating mismatch counter (built with CNT_W=2).
module tb_ff_excitation_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] tgt;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] q_fb;
    logic [3:0] exc_a;
    logic [3:0] exc_b;
    logic       done;
    logic       mismatch;
    logic [3:0] mismatch_bits;
`ifdef FF_ERR_COUNT_EN
    logic       err_clr;
    logic [1:0] err_count;
`endif

    logic [3:0] bank;
    logic [3:0] preset_val;
    logic [3:0] stuck_hi;
    logic       preset_en;
    logic [1:0] bank_mode;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ff_excitation_driver #(
        .WIDTH(4)
`ifdef FF_ERR_COUNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .tgt          (tgt),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .q_fb         (q_fb),
        .exc_a        (exc_a),
        .exc_b        (exc_b),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_bits(mismatch_bits)
`ifdef FF_ERR_COUNT_EN
        , .err_clr    (err_clr)
        , .err_count  (err_count)
`endif
    );

    // External bank; JK is realised as an SR core with S = J & ~Q, R = K & Q.
    assign q_fb = bank | stuck_hi;

    always @(posedge clk) begin
        if (rst) begin
            bank <= 4'b0000;
        end else if (preset_en) begin
            bank <= preset_val;
        end else begin
            case (bank_mode)
                2'b00:   bank <= exc_a | (~exc_b & bank);
                2'b01:   bank <= (exc_a & ~bank) | (~(exc_b & bank) & bank);
                2'b10:   bank <= exc_a;
                default: bank <= bank ^ exc_a;
            endcase
        end
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One full transaction: preset bank, accept, check APPLY excitation, CHECK, then done.
    task automatic do_txn(input string tag, input logic [1:0] m, input logic [3:0] q0,
                          input logic [3:0] t, input logic [3:0] stk, input logic [3:0] ea,
                          input logic [3:0] eb, input logic [3:0] ebits, input logic clr);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = q0;
        bank_mode  = m;
        stuck_hi   = stk;
        @(negedge clk);
        preset_en = 1'b0;
        mode      = m;
        tgt       = t;
        in_valid  = 1'b1;
        check({tag, " ready_idle"}, 4'(in_ready), 4'b0001);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " exc_a"}, exc_a, ea);
        check({tag, " exc_b"}, exc_b, eb);
        check({tag, " ready_apply"}, 4'(in_ready), 4'b0000);
        @(negedge clk);
        check({tag, " done_early"}, 4'(done), 4'b0000);
`ifdef FF_ERR_COUNT_EN
        err_clr = clr;
`else
        if (clr) $display("note: err_clr requested but counter not built");
`endif
        @(negedge clk);
`ifdef FF_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
        check({tag, " done"}, 4'(done), 4'b0001);
        check({tag, " mismatch"}, 4'(mismatch), 4'(|ebits));
        check({tag, " mismatch_bits"}, mismatch_bits, ebits);
        check({tag, " ready_back"}, 4'(in_ready), 4'b0001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        mode       = 2'b00;
        tgt        = 4'b0000;
        in_valid   = 1'b0;
        preset_en  = 1'b0;
        preset_val = 4'b0000;
        stuck_hi   = 4'b0000;
        bank_mode  = 2'b00;
`ifdef FF_ERR_COUNT_EN
        err_clr    = 1'b0;
`endif
        #1;
        check("rst exc_a", exc_a, 4'b0000);
        check("rst exc_b", exc_b, 4'b0000);
        check("rst done", 4'(done), 4'b0000);
        check("rst mismatch", 4'(mismatch), 4'b0000);
        check("rst mismatch_bits", mismatch_bits, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // JK from q=0011 to t=0101: J=0100, K=0010.
        do_txn("jk", 2'b01, 4'b0011, 4'b0101, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 1'b0);
        check("jk q_after", q_fb, 4'b0101);

        // SR clear-all with bit 2 stuck high.
        do_txn("sr_stuck", 2'b00, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 1'b0);
        @(negedge clk);
        check("sr_stuck done_pulse", 4'(done), 4'b0000);
        check("sr_stuck mismatch_hold", 4'(mismatch), 4'b0001);
        check("sr_stuck bits_hold", mismatch_bits, 4'b0100);

        do_txn("t", 2'b11, 4'b1010, 4'b0110, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 1'b0);
        check("t idle_exc_a", exc_a, 4'b0000);

        do_txn("d", 2'b10, 4'b1001, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 1'b0);
        check("d idle_track", exc_a, 4'b0110);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = 4'b0011;
        @(negedge clk);
        preset_en = 1'b0;
        check("d idle_track2", exc_a, 4'b0011);
        check("d idle_exc_b", exc_b, 4'b0000);

        // Target already reached: zero excitation, full sequence still reports done.
        do_txn("sr_same", 2'b00, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Back-to-back in T mode with in_valid held; mode/tgt scrambled while busy.
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = 4'b0000;
        bank_mode  = 2'b11;
        stuck_hi   = 4'b0000;
        @(negedge clk);
        preset_en = 1'b0;
        mode      = 2'b11;
        tgt       = 4'b0001;
        in_valid  = 1'b1;
        begin
            logic [3:0] exp_t [3];
            logic [3:0] nxt   [3];
            exp_t = '{4'b0001, 4'b0010, 4'b0100};
            nxt   = '{4'b0011, 4'b0111, 4'b0000};
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("b2b exc_a", exc_a, exp_t[i]);
                check("b2b exc_b", exc_b, 4'b0000);
                check("b2b ready_busy", 4'(in_ready), 4'b0000);
                mode = 2'b00;
                tgt  = 4'b1010;
                @(negedge clk);
                check("b2b done_early", 4'(done), 4'b0000);
                mode = 2'b11;
                tgt  = nxt[i];
                if (i == 2) in_valid = 1'b0;
                @(negedge clk);
                check("b2b done", 4'(done), 4'b0001);
                check("b2b mismatch", 4'(mismatch), 4'b0000);
                check("b2b ready", 4'(in_ready), 4'b0001);
            end
        end
        check("b2b q_final", q_fb, 4'b0111);

        // Asynchronous reset in the middle of APPLY.
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = 4'b0000;
        bank_mode  = 2'b00;
        @(negedge clk);
        preset_en = 1'b0;
        mode      = 2'b00;
        tgt       = 4'b1111;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mid exc_a_pre", exc_a, 4'b1111);
        #2 rst = 1'b1;
        #1;
        check("rst_mid exc_a", exc_a, 4'b0000);
        check("rst_mid exc_b", exc_b, 4'b0000);
        #12 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid no_done", 4'(done), 4'b0000);
            check("rst_mid ready", 4'(in_ready), 4'b0001);
        end
        check("rst_mid mismatch", 4'(mismatch), 4'b0000);

`ifdef FF_ERR_COUNT_EN
        check("cnt reset", 4'(err_count), 4'b0000);
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 5; i++) begin
                do_txn("cnt", 2'b00, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 1'b0);
                check("cnt value", 4'(err_count), 4'(exp_cnt[i]));
            end
        end
        do_txn("cnt_clr", 2'b00, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 1'b1);
        check("cnt cleared", 4'(err_count), 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
